// File: rtl/touch_spi_responder_pkg.sv
// touch_spi_pkg: shared states, channel addresses and frame constants for the touch SPI responder
package touch_spi_pkg;
    typedef enum logic [1:0] {HUNT, CMD, DATA} state_t;
    localparam logic [2:0] CH_X  = 3'b101;
    localparam logic [2:0] CH_Y  = 3'b001;
    localparam logic [2:0] CH_Z1 = 3'b011;
    localparam logic [2:0] CH_Z2 = 3'b100;
    localparam int START = 7;
    localparam int MODE = 3;
    localparam int PD0 = 0;
    localparam int FRAME_BITS = 16;
endpackage

// File: rtl/touch_spi_responder_if.sv
// touch_spi_responder_if: touch SPI link between master and responder
interface touch_spi_responder_if;
    logic i_cs;
    logic i_sck;
    logic i_sdi;
    logic o_sdo;
    logic o_irq;
    modport master(output i_cs, i_sck, i_sdi, input o_sdo, o_irq);
    modport slave(input i_cs, i_sck, i_sdi, output o_sdo, o_irq);
endinterface

// File: rtl/touch_spi_responder_result_mux.sv
// touch_result_mux: selects the addressed channel and formats it as a 12- or 8-bit frame
module touch_result_mux
    import touch_spi_pkg::*;
#(
    parameter int RES_W = 12,
    parameter logic [RES_W-1:0] AUX_VALUE = 12'h800
) (
    input  logic [2:0]            ch,
    input  logic                  mode8,
    input  logic [RES_W-1:0]      x,
    input  logic [RES_W-1:0]      y,
    input  logic [RES_W-1:0]      z1,
    input  logic [RES_W-1:0]      z2,
    output logic [FRAME_BITS-1:0] frame
);
    logic [RES_W-1:0] res;
    // channel select, then left-align the result behind a leading zero bit
    always_comb begin
        res = ch == CH_X ? x : ch == CH_Y ? y : ch == CH_Z1 ? z1 : ch == CH_Z2 ? z2 : AUX_VALUE;
        frame = mode8 ? {1'b0, res[RES_W-1 -: 8], 7'd0} : {1'b0, res, {(FRAME_BITS-1-RES_W){1'b0}}};
    end
endmodule

// File: rtl/touch_spi_responder.sv
// touch_spi_responder: XPT2046-style touch controller slave model for loopback and bring-up
module touch_spi_responder
    import touch_spi_pkg::*;
#(
    parameter int RES_W = 12,
    parameter logic [RES_W-1:0] AUX_VALUE = 12'h800
) (
    input  logic                 clk_1MHz,
    input  logic                 rst,
    touch_spi_responder_if.slave spi,
    output logic                 o_busy,
    input  logic                 i_pen_down,
    input  logic [RES_W-1:0]     i_x,
    input  logic [RES_W-1:0]     i_y,
    input  logic [RES_W-1:0]     i_z1,
    input  logic [RES_W-1:0]     i_z2,
    output logic [7:0]           o_cmd,
    output logic                 o_cmd_valid
);
    state_t state, state_nx;
    logic sck_q, rise, last_cmd, last_data, irq_en;
    logic [2:0] bitcnt;
    logic [3:0] dcnt;
    logic [7:0] cmd_sr, cmd_nx;
    logic [FRAME_BITS-1:0] out_sr, frame;
    assign rise = spi.i_sck & ~sck_q & ~spi.i_cs;
    assign last_cmd = state == CMD && rise && bitcnt == 3'd7;
    assign last_data = state == DATA && rise && dcnt == 4'(FRAME_BITS-1);
    assign cmd_nx = cmd_sr | ({7'd0, spi.i_sdi} << (3'(START) - bitcnt));
    touch_result_mux #(.RES_W(RES_W), .AUX_VALUE(AUX_VALUE)) u_mux (
        .ch(cmd_nx[6:4]),
        .mode8(cmd_nx[MODE]),
        .x(i_x),
        .y(i_y),
        .z1(i_z1),
        .z2(i_z2),
        .frame(frame)
    );
    // state register
    always_ff @(posedge clk_1MHz) begin
        if (rst) state <= HUNT;
        else state <= state_nx;
    end
    // next state: deselect always returns to HUNT
    always_comb begin
        state_nx = state;
        if (spi.i_cs) state_nx = HUNT;
        else if (state == HUNT && rise && spi.i_sdi) state_nx = CMD;
        else if (last_cmd) state_nx = DATA;
        else if (last_data) state_nx = HUNT;
    end
    // command capture, frame shifting, busy and pen interrupt
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            sck_q <= 1'b0;
            spi.o_sdo <= 1'b0;
            spi.o_irq <= 1'b1;
            o_busy <= 1'b0;
            o_cmd <= 8'h00;
            o_cmd_valid <= 1'b0;
            irq_en <= 1'b1;
            bitcnt <= '0;
            dcnt <= '0;
            cmd_sr <= '0;
            out_sr <= '0;
        end else begin
            sck_q <= spi.i_sck;
            o_cmd_valid <= last_cmd;
            spi.o_irq <= ~(i_pen_down & irq_en & spi.i_cs);
            if (spi.i_cs) begin
                spi.o_sdo <= 1'b0;
                o_busy <= 1'b0;
                bitcnt <= '0;
                dcnt <= '0;
                cmd_sr <= '0;
            end else if (rise) begin
                case (state)
                    HUNT: if (spi.i_sdi) begin
                        cmd_sr <= 8'd1 << START;
                        bitcnt <= 3'd1;
                    end
                    CMD: begin
                        cmd_sr <= cmd_nx;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            o_cmd <= cmd_nx;
                            out_sr <= frame;
                            o_busy <= 1'b1;
                            irq_en <= ~cmd_nx[PD0];
                            dcnt <= '0;
                        end
                    end
                    DATA: begin
                        out_sr <= out_sr << 1;
                        spi.o_sdo <= out_sr[FRAME_BITS-2];
                        o_busy <= 1'b0;
                        dcnt <= dcnt + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_touch_spi_responder.sv
// tb_touch_spi_responder: scoreboard bench bit-banging the touch SPI master side
module tb_touch_spi_responder;
    logic clk_1MHz = 0;
    logic rst = 1;
    logic o_busy, o_cmd_valid;
    logic i_pen_down = 0;
    logic [11:0] i_x = 12'hABC, i_y = 12'h123, i_z1 = 12'h0FF, i_z2 = 12'hFFF;
    logic [7:0] o_cmd;
    int total = 0, bad = 0;
    int vcnt = 0, bcnt = 0;
    logic [15:0] exp_q[$];
    touch_spi_responder_if spi();
    touch_spi_responder dut (
        .clk_1MHz(clk_1MHz),
        .rst(rst),
        .spi(spi),
        .o_busy(o_busy),
        .i_pen_down(i_pen_down),
        .i_x(i_x),
        .i_y(i_y),
        .i_z1(i_z1),
        .i_z2(i_z2),
        .o_cmd(o_cmd),
        .o_cmd_valid(o_cmd_valid)
    );
    always #5 clk_1MHz = ~clk_1MHz;
    // running counts of valid pulses and busy cycles
    always @(negedge clk_1MHz) begin
        if (o_cmd_valid) vcnt++;
        if (o_busy) bcnt++;
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk_1MHz);
    endtask
    task automatic xfer(input logic [7:0] cmd, input int lead, input int rises, output logic [15:0] data);
        data = '0;
        spi.i_cs = 0;
        tick(2);
        for (int i = 0; i < rises; i++) begin
            int j;
            j = i - lead;
            spi.i_sdi = (j >= 0 && j < 8) ? cmd[7-j] : 1'b0;
            tick(2);
            if (j >= 8 && j < 24) data[23-j] = spi.o_sdo;
            spi.i_sck = 1;
            tick(2);
            spi.i_sck = 0;
        end
        tick(2);
    endtask
    task automatic end_frame;
        spi.i_sck = 0;
        spi.i_sdi = 0;
        tick(1);
        spi.i_cs = 1;
        tick(3);
    endtask
    task automatic check_frame(input string name, input logic [15:0] got);
        logic [15:0] e;
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, e);
        end
    endtask
    task automatic test_reset;
        rst = 1;
        tick(3);
        total++; if (spi.o_sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b exp=0", spi.o_sdo); end
        total++; if (spi.o_irq !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b exp=1", spi.o_irq); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_cmd !== 8'h00) begin bad++; $display("FAIL reset_cmd got=%h exp=00", o_cmd); end
        total++; if (o_cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_cmd_valid); end
        rst = 0;
        tick(2);
    endtask
    task automatic test_channels;
        logic [7:0] cmds[8] = '{8'hD0, 8'hD8, 8'h90, 8'h98, 8'hB0, 8'hC0, 8'hA8, 8'h80};
        logic [15:0] exps[8] = '{16'h55E0, 16'h5580, 16'h0918, 16'h0900, 16'h07F8, 16'h7FF8, 16'h4000, 16'h4000};
        logic [15:0] d;
        int v0;
        for (int k = 0; k < 8; k++) begin
            v0 = vcnt;
            exp_q.push_back(exps[k]);
            xfer(cmds[k], 0, 24, d);
            end_frame();
            check_frame($sformatf("frame_%h", cmds[k]), d);
            total++; if (o_cmd !== cmds[k]) begin bad++; $display("FAIL cmd_%h got=%h exp=%h", cmds[k], o_cmd, cmds[k]); end
            total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL valid_%h got=%0d exp=1", cmds[k], vcnt - v0); end
        end
    endtask
    task automatic test_hold;
        logic [15:0] d;
        exp_q.push_back(16'h0918);
        fork
            xfer(8'h90, 0, 24, d);
            begin tick(40); i_y = 12'hFFF; end
        join
        end_frame();
        check_frame("hold_y", d);
        i_y = 12'h123;
    endtask
    task automatic test_leading_zeros;
        logic [15:0] d;
        int b0;
        b0 = bcnt;
        exp_q.push_back(16'h55E0);
        xfer(8'hD0, 3, 27, d);
        end_frame();
        check_frame("lead_zero", d);
        total++; if (bcnt - b0 != 4) begin bad++; $display("FAIL busy_len got=%0d exp=4", bcnt - b0); end
    endtask
    task automatic test_abort;
        logic [15:0] d;
        int v0;
        xfer(8'h90, 0, 20, d);
        total++; if (spi.o_sdo !== 1'b1) begin bad++; $display("FAIL abort_sdo_pre got=%b exp=1", spi.o_sdo); end
        spi.i_cs = 1;
        tick(1);
        total++; if (spi.o_sdo !== 1'b0) begin bad++; $display("FAIL abort_sdo got=%b exp=0", spi.o_sdo); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", o_busy); end
        end_frame();
        v0 = vcnt;
        xfer(8'hD1, 0, 5, d);
        end_frame();
        total++; if (o_cmd !== 8'h90) begin bad++; $display("FAIL partial_cmd got=%h exp=90", o_cmd); end
        total++; if (vcnt - v0 != 0) begin bad++; $display("FAIL partial_valid got=%0d exp=0", vcnt - v0); end
        exp_q.push_back(16'h55E0);
        xfer(8'hD0, 0, 24, d);
        end_frame();
        check_frame("after_abort", d);
        total++; if (o_cmd !== 8'hD0) begin bad++; $display("FAIL after_abort_cmd got=%h exp=D0", o_cmd); end
    endtask
    task automatic test_irq;
        logic [15:0] d;
        i_pen_down = 1;
        tick(2);
        total++; if (spi.o_irq !== 1'b0) begin bad++; $display("FAIL irq_pen got=%b exp=0", spi.o_irq); end
        spi.i_cs = 0;
        tick(2);
        total++; if (spi.o_irq !== 1'b1) begin bad++; $display("FAIL irq_cs_low got=%b exp=1", spi.o_irq); end
        spi.i_cs = 1;
        tick(2);
        xfer(8'hD1, 0, 24, d);
        end_frame();
        total++; if (spi.o_irq !== 1'b1) begin bad++; $display("FAIL irq_pd1 got=%b exp=1", spi.o_irq); end
        xfer(8'hD0, 0, 24, d);
        end_frame();
        total++; if (spi.o_irq !== 1'b0) begin bad++; $display("FAIL irq_pd0 got=%b exp=0", spi.o_irq); end
        rst = 1;
        tick(1);
        total++; if (spi.o_irq !== 1'b1) begin bad++; $display("FAIL irq_rst got=%b exp=1", spi.o_irq); end
        rst = 0;
        tick(2);
    endtask
    initial begin
        spi.i_cs = 1;
        spi.i_sck = 0;
        spi.i_sdi = 0;
        test_reset();
        test_channels();
        test_hold();
        test_leading_zeros();
        test_abort();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
